cl_compute_job_splitter: RTL
============================

# cl_compute_job_splitter

Fans out jobs read from the job FIFO into the six independent AXI4-Stream input channels of the PairHMM compute engine. It sits between the worker-side job FIFO and the compute engine, and mirrors the result-combining stage on the engine's output side. Each job is held until every channel has handshaken, so a slow channel back-pressures the FIFO without duplicating or dropping data on the other channels.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: width of the match, insertion, deletion, temp_A and temp_B payloads.
- `ID_WIDTH`, default 8: width of the job ID.

Ports:
- `clock_i`  in  1  single clock.
- `reset_i`  in  1  synchronous reset, active-high.
- `job_bus`  fifo_if.master_read: `read` out 1; `read_data` in (struct with `.match`, `.insertion`, `.deletion`, `.temp_A`, `.temp_B`, `.id`); `empty` in 1.
- `m_axis_match`, `m_axis_insertion`, `m_axis_deletion`, `m_axis_ta`, `m_axis_tb`  axi_stream_simple_if.master: `tvalid`/`tdata` out, `tready` in, `tdata` DATA_WIDTH bits.
- `m_axis_id`  axi_stream_simple_if.master, `tdata` ID_WIDTH bits.
- `jobs_dispatched_o`  out  32  count of fully dispatched jobs.
- `busy_o`  out  1  high when a job is held or a read is in flight.

## Operation

- FIFO read latency is 1 cycle: `read_data` is valid in the cycle after `read` is asserted. `read` is asserted only when `empty` is 0.
- FSM states:
  - IDLE: if `~empty`, assert `read` and go to FETCH.
  - FETCH: capture `read_data` into the payload registers, set all six per-channel pending bits, and go to DISPATCH.
  - DISPATCH: `tvalid[i]` equals `pending[i]`. A channel's pending bit clears on `tvalid & tready`.
  - Job completion occurs in the cycle the last pending bit clears, including the case where several channels clear in that same cycle. On completion, increment `jobs_dispatched_o`. Then: if `~empty`, assert `read` in that cycle and go to FETCH; otherwise go to IDLE.
- Payload registers and `tdata` stay stable while any channel of the job is pending.
- A channel that has already handshaken keeps `tvalid` low until the next job, even if its `tready` stays high.
- `tvalid` never depends combinationally on `tready`.
- `jobs_dispatched_o` wraps from 0xFFFFFFFF to 0.
- `busy_o` = (state != IDLE), or the skid slot is occupied when CL_JOB_SPLITTER_SKID_EN is defined.

## Timing

- Reset values: all `tvalid` 0, all `tdata` 0, `read` 0, `jobs_dispatched_o` 0, `busy_o` 0, state IDLE, pending bits 0.
- Reset mid-operation: the held job and any read in flight are discarded. FIFO data already popped is lost by design. The first `read` can assert in the cycle after reset deasserts.
- Latency: FIFO not empty at cycle 0 gives `read`=1 at cycle 0 and all `tvalid`=1 at cycle 2. Payload is registered in FETCH and visible from the next edge.
- Throughput without the macro: at most one job per 2 cycles with all `tready` high.
- A FIFO that goes empty during DISPATCH only delays the next read. It never affects the job currently held.

## Configuration

- `CL_JOB_SPLITTER_SKID_EN` defined:
  - Adds a one-job skid register, giving two slots: active and skid.
  - `read` is asserted whenever `~empty` and (free slots, counting a slot whose job completes this cycle) > (reads in flight).
  - Returned data goes to the active slot if it is free, otherwise to the skid slot.
  - On completion with the skid slot full, the skid job moves to active next cycle and pending bits are set with no FETCH bubble.
  - Sustains one job per cycle with all `tready` high and the FIFO never empty.
- Not defined: the single-slot FSM above, with no skid logic synthesized.

## Test plan

- Reset then one job (match=0x11, ins=0x22, del=0x33, ta=0x44, tb=0x55, id=0x7), all `tready`=1 -> `read` at cycle 0, all six `tvalid` high only at cycle 2 with matching `tdata`, `jobs_dispatched_o`=1, a single `read` pulse.
- Same job with `m_axis_deletion.tready` low for 5 cycles -> the other five channels handshake once and drop `tvalid`; deletion `tvalid` holds with 0x33 stable; `read` stays low until deletion handshakes; counter increments exactly then.
- 8 back-to-back jobs, all `tready`=1 -> the 8 jobs are dispatched in order with IDs 0..7, one every 2 cycles without the macro and one per cycle with CL_JOB_SPLITTER_SKID_EN; no job lost or duplicated.
- Random per-channel `tready` (50%) over 1000 jobs -> each channel's stream equals the FIFO job sequence; `jobs_dispatched_o`=1000.
- `reset_i` pulsed while in DISPATCH with 3 channels pending -> next cycle all `tvalid`=0, counter=0, FSM in IDLE; next job dispatches normally.
- Counter preset near wrap (force 0xFFFFFFFF) plus one job -> `jobs_dispatched_o`=0.

Source files
------------

// File: rtl/cl_compute_job_splitter_if.sv
// Job FIFO read port and single AXI4-Stream channel bundles used by
// cl_compute_job_splitter.
interface fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] match;
    logic [DATA_WIDTH-1:0] insertion;
    logic [DATA_WIDTH-1:0] deletion;
    logic [DATA_WIDTH-1:0] temp_A;
    logic [DATA_WIDTH-1:0] temp_B;
    logic [ID_WIDTH-1:0]   id;
  } job_t;

  logic read;
  job_t read_data;
  logic empty;

  modport master_read (output read, input read_data, input empty);
  modport slave       (input read, output read_data, output empty);
endinterface

interface axi_stream_simple_if #(
  parameter int WIDTH = 32
);
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/cl_compute_job_splitter.sv
// Fans one FIFO job out to six AXI4-Stream channels, holding it until every
// channel has handshaken. Define CL_JOB_SPLITTER_SKID_EN for a second job slot.
module cl_compute_job_splitter #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) (
  input  logic                clock_i,
  input  logic                reset_i,
  fifo_if.master_read         job_bus,
  axi_stream_simple_if.master m_axis_match,
  axi_stream_simple_if.master m_axis_insertion,
  axi_stream_simple_if.master m_axis_deletion,
  axi_stream_simple_if.master m_axis_ta,
  axi_stream_simple_if.master m_axis_tb,
  axi_stream_simple_if.master m_axis_id,
  output logic [31:0]         jobs_dispatched_o,
  output logic                busy_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] match;
    logic [DATA_WIDTH-1:0] insertion;
    logic [DATA_WIDTH-1:0] deletion;
    logic [DATA_WIDTH-1:0] temp_A;
    logic [DATA_WIDTH-1:0] temp_B;
    logic [ID_WIDTH-1:0]   id;
  } job_t;

  job_t        act;
  logic [5:0]  pending;
  logic [5:0]  ready;
  logic        done;
  logic [31:0] dispatched;

  // Channel order: match, insertion, deletion, temp_A, temp_B, id.
  assign ready = {m_axis_id.tready, m_axis_tb.tready, m_axis_ta.tready,
                  m_axis_deletion.tready, m_axis_insertion.tready, m_axis_match.tready};
  assign done  = (pending != '0) && ((pending & ~ready) == '0);

  assign m_axis_match.tvalid     = pending[0];
  assign m_axis_insertion.tvalid = pending[1];
  assign m_axis_deletion.tvalid  = pending[2];
  assign m_axis_ta.tvalid        = pending[3];
  assign m_axis_tb.tvalid        = pending[4];
  assign m_axis_id.tvalid        = pending[5];

  assign m_axis_match.tdata     = act.match;
  assign m_axis_insertion.tdata = act.insertion;
  assign m_axis_deletion.tdata  = act.deletion;
  assign m_axis_ta.tdata        = act.temp_A;
  assign m_axis_tb.tdata        = act.temp_B;
  assign m_axis_id.tdata        = act.id;

  assign jobs_dispatched_o = dispatched;

`ifdef CL_JOB_SPLITTER_SKID_EN
  job_t       skid;
  logic       skid_valid;
  logic       in_flight;
  logic       active_free;
  logic [1:0] free_slots;

  // A slot whose job completes this cycle counts as free, so a read can
  // overlap the last handshake and keep one job per cycle.
  assign active_free = (pending == '0) | done;
  assign free_slots  = {1'b0, active_free} + {1'b0, ~skid_valid};
  assign job_bus.read = ~reset_i & ~job_bus.empty & (free_slots > {1'b0, in_flight});
  assign busy_o = (pending != '0) | in_flight | skid_valid;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      act        <= '0;
      skid       <= '0;
      pending    <= '0;
      skid_valid <= 1'b0;
      in_flight  <= 1'b0;
      dispatched <= '0;
    end else begin
      in_flight <= job_bus.read;
      if (done) dispatched <= dispatched + 32'd1;
      if (active_free) begin
        if (skid_valid) begin
          act        <= skid;
          pending    <= '1;
          skid_valid <= in_flight;
          if (in_flight) skid <= job_bus.read_data;
        end else if (in_flight) begin
          act     <= job_bus.read_data;
          pending <= '1;
        end else begin
          pending <= '0;
        end
      end else begin
        pending <= pending & ~ready;
        if (in_flight) begin
          skid       <= job_bus.read_data;
          skid_valid <= 1'b1;
        end
      end
    end
  end
`else
  typedef enum logic [1:0] {IDLE, FETCH, DISPATCH} state_t;
  state_t state;

  assign job_bus.read = ~reset_i & ~job_bus.empty &
                        ((state == IDLE) | ((state == DISPATCH) & done));
  assign busy_o = (state != IDLE);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state      <= IDLE;
      act        <= '0;
      pending    <= '0;
      dispatched <= '0;
    end else begin
      case (state)
        IDLE: if (!job_bus.empty) state <= FETCH;
        FETCH: begin
          act     <= job_bus.read_data;
          pending <= '1;
          state   <= DISPATCH;
        end
        DISPATCH: begin
          pending <= pending & ~ready;
          if (done) begin
            dispatched <= dispatched + 32'd1;
            state      <= job_bus.empty ? IDLE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
